// File: rtl/fetch_btb_stage.sv
// Instruction-fetch stage: PC register, direct-mapped BTB next-PC prediction, IF/ID register.
// Define FETCH_BTB_EN to build the BTB; without it the stage always predicts pc+4.
module fetch_btb_stage #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned BTB_IDX_BITS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipeline_en,
    input  logic        pipeline_flush,
    input  logic [31:0] ex_redirect_pc,
    input  logic        ex_update_valid,
    input  logic [31:0] ex_update_pc,
    input  logic        ex_update_taken,
    input  logic [31:0] ex_update_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] id_pc,
    output logic [31:0] id_instruction,
    output logic        id_pred_taken,
    output logic [31:0] id_pred_target,
    output logic        id_valid
);

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    logic [31:0] pc_q, pc_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_instruction_q, id_instruction_d;
    logic        id_pred_taken_q, id_pred_taken_d;
    logic [31:0] id_pred_target_q, id_pred_target_d;
    logic        id_valid_q, id_valid_d;

    logic        pred_taken;
    logic [31:0] pred_target;

`ifdef FETCH_BTB_EN
    localparam int unsigned BTB_ENTRIES = 1 << BTB_IDX_BITS;
    localparam int unsigned TAG_W       = 30 - BTB_IDX_BITS;

    logic              btb_valid_q  [BTB_ENTRIES];
    logic              btb_valid_d  [BTB_ENTRIES];
    logic [TAG_W-1:0]  btb_tag_q    [BTB_ENTRIES];
    logic [TAG_W-1:0]  btb_tag_d    [BTB_ENTRIES];
    logic [31:0]       btb_target_q [BTB_ENTRIES];
    logic [31:0]       btb_target_d [BTB_ENTRIES];
    logic [1:0]        btb_state_q  [BTB_ENTRIES];
    logic [1:0]        btb_state_d  [BTB_ENTRIES];

    logic [BTB_IDX_BITS-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0]        lk_tag, up_tag;
    logic                    up_hit;
    logic [1:0]              unused_up_lsb;

    assign lk_idx        = pc_q[BTB_IDX_BITS+1:2];
    assign lk_tag        = pc_q[31:BTB_IDX_BITS+2];
    assign up_idx        = ex_update_pc[BTB_IDX_BITS+1:2];
    assign up_tag        = ex_update_pc[31:BTB_IDX_BITS+2];
    assign unused_up_lsb = ex_update_pc[1:0];
    assign up_hit        = btb_valid_q[up_idx] && (btb_tag_q[up_idx] == up_tag);

    // Lookup reads the registered array, so a same-cycle update is seen only after the edge.
    assign pred_taken  = btb_valid_q[lk_idx] && (btb_tag_q[lk_idx] == lk_tag) && btb_state_q[lk_idx][1];
    assign pred_target = btb_target_q[lk_idx];

    always_comb begin
        btb_valid_d  = btb_valid_q;
        btb_tag_d    = btb_tag_q;
        btb_target_d = btb_target_q;
        btb_state_d  = btb_state_q;
        if (ex_update_valid) begin
            if (up_hit) begin
                if (ex_update_taken) begin
                    btb_target_d[up_idx] = ex_update_target;
                    case (btb_state_q[up_idx])
                        2'b00:   btb_state_d[up_idx] = 2'b01;
                        2'b01:   btb_state_d[up_idx] = 2'b11;
                        default: btb_state_d[up_idx] = 2'b10;
                    endcase
                end else begin
                    case (btb_state_q[up_idx])
                        2'b10:   btb_state_d[up_idx] = 2'b11;
                        2'b11:   btb_state_d[up_idx] = 2'b01;
                        default: btb_state_d[up_idx] = 2'b00;
                    endcase
                end
            end else if (ex_update_taken) begin
                btb_valid_d[up_idx]  = 1'b1;
                btb_tag_d[up_idx]    = up_tag;
                btb_target_d[up_idx] = ex_update_target;
                btb_state_d[up_idx]  = 2'b11;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < BTB_ENTRIES; i++) begin
                btb_valid_q[i]  <= 1'b0;
                btb_tag_q[i]    <= '0;
                btb_target_q[i] <= '0;
                btb_state_q[i]  <= 2'b00;
            end
        end else begin
            btb_valid_q  <= btb_valid_d;
            btb_tag_q    <= btb_tag_d;
            btb_target_q <= btb_target_d;
            btb_state_q  <= btb_state_d;
        end
    end
`else
    logic unused_ex_update;

    assign pred_taken       = 1'b0;
    assign pred_target      = '0;
    assign unused_ex_update = ^{ex_update_valid, ex_update_pc, ex_update_taken, ex_update_target};
`endif

    always_comb begin
        pc_d             = pc_q;
        id_pc_d          = id_pc_q;
        id_instruction_d = id_instruction_q;
        id_pred_taken_d  = id_pred_taken_q;
        id_pred_target_d = id_pred_target_q;
        id_valid_d       = id_valid_q;
        if (pipeline_flush) begin
            pc_d             = ex_redirect_pc;
            id_pc_d          = ex_redirect_pc;
            id_instruction_d = NOP_INSN;
            id_pred_taken_d  = 1'b0;
            id_pred_target_d = '0;
            id_valid_d       = 1'b0;
        end else if (pipeline_en) begin
            pc_d             = pred_taken ? pred_target : pc_q + 32'd4;
            id_pc_d          = pc_q;
            id_instruction_d = imem_rdata;
            id_pred_taken_d  = pred_taken;
            id_pred_target_d = pred_taken ? pred_target : '0;
            id_valid_d       = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q             <= RESET_PC;
            id_pc_q          <= '0;
            id_instruction_q <= NOP_INSN;
            id_pred_taken_q  <= 1'b0;
            id_pred_target_q <= '0;
            id_valid_q       <= 1'b0;
        end else begin
            pc_q             <= pc_d;
            id_pc_q          <= id_pc_d;
            id_instruction_q <= id_instruction_d;
            id_pred_taken_q  <= id_pred_taken_d;
            id_pred_target_q <= id_pred_target_d;
            id_valid_q       <= id_valid_d;
        end
    end

    assign imem_addr      = pc_q;
    assign id_pc          = id_pc_q;
    assign id_instruction = id_instruction_q;
    assign id_pred_taken  = id_pred_taken_q;
    assign id_pred_target = id_pred_target_q;
    assign id_valid       = id_valid_q;

endmodule
